hdmi_in_core: RTL and testbench
===============================

// Module: hdmi_in_core
// PURPOSE
//  Receive-side counterpart of the HDMI output timing core. Samples an incoming RGB/hsync/vsync/ve
//  video stream in the pixel clock domain and detects sync polarity. Measures line/frame timing and
//  locks once timing is stable, then forwards active pixels through a small FIFO as a ready/valid
//  stream to the frame-buffer writer.
// PARAMETERS
//  LOCK_FRAMES  2   consecutive identical frames required to assert locked (1..15)
//  CNT_W        16  width of timing counters, htotal_o, vtotal_o
//  FIFO_AW      4   log2 pixel FIFO depth (depth 16)
// PORTS
//  clock        in   1      pixel clock; all logic on posedge
//  reset_n      in   1      synchronous reset, active low
//  enable       in   1      0 = hold in SEARCH, flush FIFO, clear overflow
//  hsync_in     in   1      incoming hsync, either polarity
//  vsync_in     in   1      incoming vsync, either polarity
//  ve_in        in   1      incoming video-enable (active high)
//  red_in       in   8      pixel red
//  green_in     in   8      pixel green
//  blue_in      in   8      pixel blue
//  pixel_data   out  32     {red,green,blue,8'h00} (same packing as core color word)
//  pixel_sof    out  1      entry is first pixel of frame
//  pixel_sol    out  1      entry is first pixel of a line
//  pixel_valid  out  1      FIFO head valid
//  pixel_ready  in   1      consumer accepts head when valid&&ready
//  locked       out  1      timing stable, pixels being forwarded
//  overflow     out  1      sticky: pixel dropped because FIFO full
//  hsync_pol    out  1      detected active hsync level
//  vsync_pol    out  1      detected active vsync level
//  hres_o       out  11     active pixels/line of last complete frame, saturates 2047
//  vres_o       out  10     active lines/frame, saturates 1023
//  htotal_o     out  CNT_W  clocks between hsync active edges
//  vtotal_o     out  CNT_W  lines between vsync active edges
// BEHAVIOUR
//  - Reset (reset_n=0 at edge): all outputs 0, FIFO empty, state SEARCH. Mid-frame reset discards all.
//  - Inputs registered once (stage S1); edge detect/compare at S2; FIFO write at S2.
//  - Polarity: sampled while ve=1 (syncs inactive): *_pol = ~sampled level. Updated every ve cycle.
//  - Sync edge = transition into active level. Line = hsync edge to next; frame = vsync edge to next.
//  - hcnt: clocks since hsync edge; vcnt: hsync edges since vsync edge; pcnt: ve cycles in line;
//    lcnt: lines containing >=1 ve cycle. All counters saturate, never wrap.
//  - At vsync edge: latch htotal (last line), hres (last active line's pcnt), vtotal, vres into
//    *_o; compare with previous latched set.
//  - FSM: SEARCH -> (first ve seen, then vsync edge) MEASURE;
//    MEASURE: match -> ++match_cnt; mismatch -> match_cnt=0; match_cnt==LOCK_FRAMES-1 -> LOCKED;
//    LOCKED: locked=1; any mismatch at vsync edge -> MEASURE, locked=0 same cycle.
//    enable=0 from any state -> SEARCH next cycle, match_cnt=0, locked=0.
//  - Forwarding only in LOCKED, starting at the frame after lock (first pixel tagged sof).
//    sol tags first ve cycle of every line.
//  - FIFO: show-ahead; empty FIFO, ready=1: pixel on inputs at cycle N visible on pixel_data at N+3.
//    Pop on valid&&ready; simultaneous push/pop at full is legal (no drop).
//    Push when full and no pop -> pixel dropped, overflow=1 until enable=0 or reset.
//  - Lock loss: FIFO contents kept and drained; no new pushes.
// CONFIGURATION
//  HDMI_IN_WATCHDOG_EN defined: hcnt reaching 2^CNT_W-1 (no hsync) -> SEARCH, locked=0,
//    *_o cleared to 0, FIFO flushed.
//  Not defined: counters saturate, state and *_o hold until next sync edge.
// TESTING
//  1280x720 pos pol (htotal 1650, vtotal 750) -> after 2 frames locked=1, hres_o=1280, vres_o=720, pol=1/1.
//  800x600 neg pol (1056/628) -> hsync_pol=0, vsync_pol=0, htotal_o=1056, vtotal_o=628.
//  Locked 640x480; change htotal 800->801 -> locked=0 at next vsync edge, relock after 2 frames.
//  pixel_ready=0 for 20 active cycles -> 16 stored, overflow=1, first popped has sof=1.
//  Single pixel 0xAABBCC, empty FIFO, ready=1 -> pixel_data=32'hAABBCC00 exactly 3 cycles later.
//  reset_n=0 mid-line for 1 cycle -> all outputs 0 next cycle; relock needs full SEARCH/MEASURE.

Source files
------------

// File: rtl/hdmi_in_core.sv
// HDMI receive timing core: polarity detect, line/frame measurement, lock FSM, pixel FIFO.
// Optional macro HDMI_IN_WATCHDOG_EN: a saturated hcnt (lost hsync) drops lock and clears state.
module hdmi_in_core #(
  parameter int unsigned LOCK_FRAMES = 2,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned FIFO_AW     = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic             ve_in,
  input  logic [7:0]       red_in,
  input  logic [7:0]       green_in,
  input  logic [7:0]       blue_in,
  output logic [31:0]      pixel_data,
  output logic             pixel_sof,
  output logic             pixel_sol,
  output logic             pixel_valid,
  input  logic             pixel_ready,
  output logic             locked,
  output logic             overflow,
  output logic             hsync_pol,
  output logic             vsync_pol,
  output logic [10:0]      hres_o,
  output logic [9:0]       vres_o,
  output logic [CNT_W-1:0] htotal_o,
  output logic [CNT_W-1:0] vtotal_o
);

  localparam int unsigned Depth = 1 << FIFO_AW;

  typedef enum logic [1:0] {StSearch, StMeasure, StLocked} state_e;

  function automatic logic [CNT_W-1:0] inc_sat(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic             hs1_q, vs1_q, ve1_q;
  logic [23:0]      rgb1_q;
  logic             hs_prev_q, vs_prev_q, hpol_q, vpol_q;
  logic             h_edge, v_edge, line_has_px, wd_trip, frame_match;
  logic [CNT_W-1:0] hcnt_q, vcnt_q, pcnt_q, lcnt_q, htot_last_q, hres_last_q;
  logic [CNT_W-1:0] ln_htot, ln_hres, lcnt_now;
  logic [10:0]      hres_sat;
  logic [9:0]       vres_sat;
  state_e           state_q, state_d;
  logic [3:0]       match_q, match_d;
  logic             seen_q, seen_d;

  // Stage S1: plain input registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      hs1_q  <= 1'b0;
      vs1_q  <= 1'b0;
      ve1_q  <= 1'b0;
      rgb1_q <= '0;
    end else begin
      hs1_q  <= hsync_in;
      vs1_q  <= vsync_in;
      ve1_q  <= ve_in;
      rgb1_q <= {red_in, green_in, blue_in};
    end
  end

  assign h_edge      = (hs1_q == hpol_q) && (hs_prev_q != hpol_q);
  assign v_edge      = (vs1_q == vpol_q) && (vs_prev_q != vpol_q);
  assign line_has_px = (pcnt_q != '0);

  // Line ending on this very cycle must count toward a coincident vsync edge
  assign ln_htot  = h_edge ? hcnt_q : htot_last_q;
  assign ln_hres  = (h_edge && line_has_px) ? pcnt_q : hres_last_q;
  assign lcnt_now = (h_edge && line_has_px) ? inc_sat(lcnt_q) : lcnt_q;
  assign hres_sat = (ln_hres > CNT_W'(11'h7ff)) ? 11'h7ff : ln_hres[10:0];
  assign vres_sat = (lcnt_now > CNT_W'(10'h3ff)) ? 10'h3ff : lcnt_now[9:0];

  assign frame_match = (htotal_o == ln_htot) && (vtotal_o == vcnt_q) &&
                       (hres_o == hres_sat) && (vres_o == vres_sat);

`ifdef HDMI_IN_WATCHDOG_EN
  assign wd_trip = &hcnt_q;
`else
  assign wd_trip = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      hs_prev_q   <= 1'b0;
      vs_prev_q   <= 1'b0;
      hpol_q      <= 1'b0;
      vpol_q      <= 1'b0;
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      pcnt_q      <= '0;
      lcnt_q      <= '0;
      htot_last_q <= '0;
      hres_last_q <= '0;
    end else begin
      hs_prev_q <= hs1_q;
      vs_prev_q <= vs1_q;
      // Syncs are inactive during active video, so their level there is the inactive one
      if (ve1_q) begin
        hpol_q <= ~hs1_q;
        vpol_q <= ~vs1_q;
      end
      if (h_edge) begin
        hcnt_q      <= CNT_W'(1);
        htot_last_q <= hcnt_q;
        pcnt_q      <= CNT_W'(ve1_q);
        if (line_has_px) hres_last_q <= pcnt_q;
      end else begin
        hcnt_q <= inc_sat(hcnt_q);
        if (ve1_q) pcnt_q <= inc_sat(pcnt_q);
      end
      if (v_edge) begin
        vcnt_q <= CNT_W'(h_edge);
        lcnt_q <= '0;
      end else begin
        if (h_edge) vcnt_q <= inc_sat(vcnt_q);
        lcnt_q <= lcnt_now;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n || wd_trip) begin
      htotal_o <= '0;
      vtotal_o <= '0;
      hres_o   <= '0;
      vres_o   <= '0;
    end else if (v_edge) begin
      htotal_o <= ln_htot;
      vtotal_o <= vcnt_q;
      hres_o   <= hres_sat;
      vres_o   <= vres_sat;
    end
  end

  assign hsync_pol = hpol_q;
  assign vsync_pol = vpol_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= StSearch;
      match_q <= '0;
      seen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
      seen_q  <= seen_d;
    end
  end

  always_comb begin
    state_d = state_q;
    match_d = match_q;
    seen_d  = seen_q;
    unique case (state_q)
      StSearch: begin
        if (ve1_q) seen_d = 1'b1;
        if ((seen_q || ve1_q) && v_edge) begin
          state_d = StMeasure;
          match_d = '0;
          seen_d  = 1'b0;
        end
      end
      StMeasure: begin
        if (v_edge) begin
          if (frame_match) begin
            if (32'(match_q) + 32'd1 >= LOCK_FRAMES - 32'd1) state_d = StLocked;
            match_d = match_q + 4'd1;
          end else begin
            match_d = '0;
          end
        end
      end
      StLocked: begin
        if (v_edge && !frame_match) begin
          state_d = StMeasure;
          match_d = '0;
        end
      end
      default: state_d = StSearch;
    endcase
    if (!enable || wd_trip) begin
      state_d = StSearch;
      match_d = '0;
      seen_d  = 1'b0;
    end
  end

  assign locked = (state_q == StLocked);

  // Stage S2: tagged pixel waiting to be written into the FIFO
  logic        sof_pend_q, flush, push_s1, sol_s1, sof_s1;
  logic        s2_push_q, s2_sof_q, s2_sol_q;
  logic [31:0] s2_data_q;

  assign flush   = !enable || wd_trip;
  assign push_s1 = locked && ve1_q;
  assign sol_s1  = ve1_q && (h_edge || !line_has_px);
  assign sof_s1  = v_edge || sof_pend_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sof_pend_q <= 1'b0;
    end else if (v_edge) begin
      sof_pend_q <= 1'b1;
    end else if (ve1_q) begin
      sof_pend_q <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n || flush) begin
      s2_push_q <= 1'b0;
      s2_sof_q  <= 1'b0;
      s2_sol_q  <= 1'b0;
      s2_data_q <= '0;
    end else begin
      s2_push_q <= push_s1;
      s2_sof_q  <= sof_s1;
      s2_sol_q  <= sol_s1;
      s2_data_q <= {rgb1_q, 8'h00};
    end
  end

  logic [33:0]      mem_q [Depth];
  logic [FIFO_AW:0] wr_ptr_q, rd_ptr_q;
  logic             empty, full, pop, wr_en, drop;
  logic [33:0]      head;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                 (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
  assign pop   = !empty && pixel_ready;
  assign wr_en = s2_push_q && (!full || pop);
  assign drop  = s2_push_q && full && !pop;

  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= {s2_sof_q, s2_sol_q, s2_data_q};
  end

  always_ff @(posedge clock) begin
    if (!reset_n || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (drop) overflow <= 1'b1;
    end
  end

  assign head        = mem_q[rd_ptr_q[FIFO_AW-1:0]];
  assign pixel_valid = !empty;
  assign pixel_data  = empty ? 32'h0 : head[31:0];
  assign pixel_sol   = !empty && head[32];
  assign pixel_sof   = !empty && head[33];

endmodule

// File: tb/tb_hdmi_in_core.sv
// Directed bench for hdmi_in_core using scaled-down video formats.
module tb_hdmi_in_core;

  logic        clock = 1'b0;
  logic        reset_n, enable, hsync_in, vsync_in, ve_in, pixel_ready;
  logic [7:0]  red_in, green_in, blue_in;
  logic [31:0] pixel_data;
  logic        pixel_sof, pixel_sol, pixel_valid, locked, overflow, hsync_pol, vsync_pol;
  logic [10:0] hres_o;
  logic [9:0]  vres_o;
  logic [15:0] htotal_o, vtotal_o;

  hdmi_in_core #(.LOCK_FRAMES(2), .CNT_W(16), .FIFO_AW(4)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .ve_in(ve_in),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .pixel_data(pixel_data), .pixel_sof(pixel_sof), .pixel_sol(pixel_sol),
    .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
    .locked(locked), .overflow(overflow), .hsync_pol(hsync_pol), .vsync_pol(vsync_pol),
    .hres_o(hres_o), .vres_o(vres_o), .htotal_o(htotal_o), .vtotal_o(vtotal_o)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic        sof;
    logic        sol;
    int          c;
  } pop_t;
  pop_t pops[$];

  always @(negedge clock) begin
    pop_t p;
    if (pixel_valid && pixel_ready) begin
      p.data = pixel_data;
      p.sof  = pixel_sof;
      p.sol  = pixel_sol;
      p.c    = cyc;
      pops.push_back(p);
    end
  end

  int htot, hsw, hstart, hact, vtot, vsw, vstart, vact;
  logic hp, vp;
  logic fix_en = 1'b0;
  logic [23:0] fix_rgb = 24'h0;
  int frame_id = 0;
  int last_ve_cyc = 0;

  task automatic set_fmt(input int ht, input int hw, input int hs, input int ha, input int vt,
                         input int vw, input int vs, input int va, input logic hpl,
                         input logic vpl);
    htot = ht; hsw = hw; hstart = hs; hact = ha;
    vtot = vt; vsw = vw; vstart = vs; vact = va;
    hp = hpl; vp = vpl;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock); #1;
      hsync_in = ~hp; vsync_in = ~vp; ve_in = 1'b0;
      {red_in, green_in, blue_in} = 24'h0;
    end
  endtask

  task automatic send_lines(input int first, input int last);
    logic ve;
    for (int l = first; l <= last; l++) begin
      for (int h = 0; h < htot; h++) begin
        ve = (l >= vstart) && (l < vstart + vact) && (h >= hstart) && (h < hstart + hact);
        @(posedge clock); #1;
        hsync_in = (h < hsw) ? hp : ~hp;
        vsync_in = (l >= vtot - vsw) ? vp : ~vp;
        ve_in = ve;
        if (!ve) {red_in, green_in, blue_in} = 24'h0;
        else if (fix_en) {red_in, green_in, blue_in} = fix_rgb;
        else {red_in, green_in, blue_in} = {8'(l), 8'(h - hstart), 8'(frame_id)};
        if (ve) last_ve_cyc = cyc;
      end
    end
  endtask

  task automatic send_frame();
    send_lines(0, vtot - 1);
    frame_id++;
  endtask

  task automatic resync();
    enable = 1'b0;
    idle(3);
    enable = 1'b1;
    idle(2);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle(3);
    checks++;
    if ({pixel_valid, locked, overflow, hsync_pol, vsync_pol, pixel_sof, pixel_sol} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000000",
               {pixel_valid, locked, overflow, hsync_pol, vsync_pol, pixel_sof, pixel_sol});
    end
    checks++;
    if (pixel_data !== 32'h0) begin
      errors++; $display("FAIL reset_data: got %h expected 0", pixel_data);
    end
    checks++;
    if ({hres_o, vres_o} !== 21'h0) begin
      errors++; $display("FAIL reset_res: got %0d/%0d expected 0/0", hres_o, vres_o);
    end
    checks++;
    if ({htotal_o, vtotal_o} !== 32'h0) begin
      errors++; $display("FAIL reset_tot: got %0d/%0d expected 0/0", htotal_o, vtotal_o);
    end
    reset_n = 1'b1;
    idle(2);
  endtask

  task automatic test_pos_pol();
    int fid, bad, nsof, nsol;
    logic [31:0] exp;
    send_frame();
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL pos_lock_f0: got %b expected 0", locked); end
    send_frame();
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL pos_lock_f1: got %b expected 0", locked); end
    send_frame();
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL pos_lock_f2: got %b expected 1", locked); end
    checks++;
    if (hres_o !== 11'd12 || vres_o !== 10'd5) begin
      errors++; $display("FAIL pos_res: got %0d x %0d expected 12 x 5", hres_o, vres_o);
    end
    checks++;
    if (htotal_o !== 16'd24 || vtotal_o !== 16'd12) begin
      errors++; $display("FAIL pos_tot: got %0d/%0d expected 24/12", htotal_o, vtotal_o);
    end
    checks++;
    if (hsync_pol !== 1'b1 || vsync_pol !== 1'b1) begin
      errors++; $display("FAIL pos_pol: got %b/%b expected 1/1", hsync_pol, vsync_pol);
    end
    pops.delete();
    fid = frame_id;
    send_frame();
    idle(8);
    checks++;
    if (pops.size() != 60) begin
      errors++; $display("FAIL pos_pixel_count: got %0d expected 60", pops.size());
    end
    bad = 0; nsof = 0; nsol = 0;
    foreach (pops[k]) begin
      exp = {8'(2 + k / 12), 8'(k % 12), 8'(fid), 8'h00};
      if (pops[k].data !== exp || pops[k].sof !== (k == 0) || pops[k].sol !== (k % 12 == 0))
        bad++;
      if (pops[k].sof) nsof++;
      if (pops[k].sol) nsol++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL pos_pixel_stream: got %0d bad entries expected 0", bad); end
    checks++;
    if (nsof != 1 || nsol != 5) begin
      errors++; $display("FAIL pos_tags: got sof=%0d sol=%0d expected 1/5", nsof, nsol);
    end
  endtask

  task automatic test_neg_pol();
    set_fmt(30, 4, 8, 10, 14, 3, 3, 4, 1'b0, 1'b0);
    resync();
    send_frame();
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL neg_lock_f0: got %b expected 0", locked); end
    send_frame();
    send_frame();
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL neg_lock_f2: got %b expected 1", locked); end
    checks++;
    if (hsync_pol !== 1'b0 || vsync_pol !== 1'b0) begin
      errors++; $display("FAIL neg_pol: got %b/%b expected 0/0", hsync_pol, vsync_pol);
    end
    checks++;
    if (htotal_o !== 16'd30 || vtotal_o !== 16'd14) begin
      errors++; $display("FAIL neg_tot: got %0d/%0d expected 30/14", htotal_o, vtotal_o);
    end
    checks++;
    if (hres_o !== 11'd10 || vres_o !== 10'd4) begin
      errors++; $display("FAIL neg_res: got %0d x %0d expected 10 x 4", hres_o, vres_o);
    end
  endtask

  task automatic test_relock();
    htot = 31;
    send_lines(0, vtot - vsw - 1);
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL relock_before_edge: got %b expected 1", locked); end
    send_lines(vtot - vsw, vtot - 1);
    frame_id++;
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL relock_lost: got %b expected 0", locked); end
    checks++;
    if (htotal_o !== 16'd31) begin errors++; $display("FAIL relock_htot: got %0d expected 31", htotal_o); end
    send_frame();
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL relock_regained: got %b expected 1", locked); end
  endtask

  task automatic test_overflow();
    int fid;
    set_fmt(32, 3, 6, 20, 6, 2, 1, 1, 1'b1, 1'b1);
    resync();
    repeat (3) send_frame();
    idle(4);
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL ovf_lock: got %b expected 1", locked); end
    pixel_ready = 1'b0;
    pops.delete();
    fid = frame_id;
    send_frame();
    idle(4);
    checks++;
    if (overflow !== 1'b1 || pixel_valid !== 1'b1) begin
      errors++; $display("FAIL ovf_flag: got ovf=%b valid=%b expected 1/1", overflow, pixel_valid);
    end
    pixel_ready = 1'b1;
    idle(24);
    checks++;
    if (pops.size() != 16) begin errors++; $display("FAIL ovf_stored: got %0d expected 16", pops.size()); end
    if (pops.size() == 16) begin
      checks++;
      if (pops[0].sof !== 1'b1 || pops[0].data !== {8'd1, 8'd0, 8'(fid), 8'h00}) begin
        errors++;
        $display("FAIL ovf_first: got sof=%b data=%h expected 1/%h", pops[0].sof, pops[0].data,
                 {8'd1, 8'd0, 8'(fid), 8'h00});
      end
      checks++;
      if (pops[15].data !== {8'd1, 8'd15, 8'(fid), 8'h00}) begin
        errors++; $display("FAIL ovf_last: got %h expected %h", pops[15].data,
                           {8'd1, 8'd15, 8'(fid), 8'h00});
      end
    end
    checks++;
    if (overflow !== 1'b1 || pixel_valid !== 1'b0) begin
      errors++; $display("FAIL ovf_sticky: got ovf=%b valid=%b expected 1/0", overflow, pixel_valid);
    end
    enable = 1'b0;
    idle(1);
    checks++;
    if (overflow !== 1'b0 || locked !== 1'b0) begin
      errors++; $display("FAIL ovf_clear: got ovf=%b locked=%b expected 0/0", overflow, locked);
    end
    enable = 1'b1;
  endtask

  task automatic test_latency();
    set_fmt(16, 2, 5, 1, 5, 2, 1, 1, 1'b1, 1'b1);
    fix_en = 1'b1;
    fix_rgb = 24'hAABBCC;
    resync();
    repeat (3) send_frame();
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL lat_lock: got %b expected 1", locked); end
    pops.delete();
    send_frame();
    idle(4);
    checks++;
    if (pops.size() != 1) begin errors++; $display("FAIL lat_count: got %0d expected 1", pops.size()); end
    if (pops.size() >= 1) begin
      checks++;
      if (pops[0].data !== 32'hAABBCC00) begin
        errors++; $display("FAIL lat_data: got %h expected aabbcc00", pops[0].data);
      end
      checks++;
      if (pops[0].c - last_ve_cyc != 3) begin
        errors++; $display("FAIL lat_cycles: got %0d expected 3", pops[0].c - last_ve_cyc);
      end
      checks++;
      if (pops[0].sof !== 1'b1 || pops[0].sol !== 1'b1) begin
        errors++; $display("FAIL lat_tags: got %b/%b expected 1/1", pops[0].sof, pops[0].sol);
      end
    end
    fix_en = 1'b0;
  endtask

  task automatic test_mid_reset();
    set_fmt(24, 3, 6, 12, 12, 2, 2, 5, 1'b1, 1'b1);
    resync();
    repeat (3) send_frame();
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL mrst_pre_lock: got %b expected 1", locked); end
    fork
      send_frame();
      begin
        repeat (5) @(posedge clock);
        #2 reset_n = 1'b0;
        @(posedge clock);
        #2;
        checks++;
        if ({locked, hsync_pol, vsync_pol, pixel_valid, overflow} !== 5'b0) begin
          errors++;
          $display("FAIL mrst_flags: got %b expected 00000",
                   {locked, hsync_pol, vsync_pol, pixel_valid, overflow});
        end
        checks++;
        if ({hres_o, vres_o, htotal_o, vtotal_o} !== 53'h0) begin
          errors++; $display("FAIL mrst_meas: got %0d %0d %0d %0d expected 0 0 0 0",
                             hres_o, vres_o, htotal_o, vtotal_o);
        end
        reset_n = 1'b1;
      end
    join
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL mrst_f0: got %b expected 0", locked); end
    send_frame();
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL mrst_f1: got %b expected 0", locked); end
    send_frame();
    checks++;
    if (locked !== 1'b1 || hres_o !== 11'd12) begin
      errors++; $display("FAIL mrst_relock: got locked=%b hres=%0d expected 1/12", locked, hres_o);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    enable = 1'b1;
    pixel_ready = 1'b1;
    set_fmt(24, 3, 6, 12, 12, 2, 2, 5, 1'b1, 1'b1);
    hsync_in = 1'b0; vsync_in = 1'b0; ve_in = 1'b0;
    red_in = 8'h0; green_in = 8'h0; blue_in = 8'h0;
    test_reset();
    test_pos_pol();
    test_neg_pol();
    test_relock();
    test_overflow();
    test_latency();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
